// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer handshakes and CDB broadcast bundle for cdb_arbiter
//
// Purpose: groups the ALU and LSB result handshakes and the registered CDB
//   broadcast into one bundle.
// Signals:
//   alu_valid_in / alu_ready_out / alu_value_in / alu_tag_in  ALU result handshake
//   mem_valid_in / mem_ready_out / mem_value_in / mem_tag_in  LSB result handshake
//   cdb_valid_out / cdb_value_out / cdb_tag_out / cdb_src_out broadcast (src 0=ALU, 1=LSB)
// Modports:
//   master - producers and CDB consumers
//   slave  - the arbiter
interface cdb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
);
  logic                  alu_valid_in;
  logic                  alu_ready_out;
  logic [DATA_WIDTH-1:0] alu_value_in;
  logic [TAG_WIDTH-1:0]  alu_tag_in;

  logic                  mem_valid_in;
  logic                  mem_ready_out;
  logic [DATA_WIDTH-1:0] mem_value_in;
  logic [TAG_WIDTH-1:0]  mem_tag_in;

  logic                  cdb_valid_out;
  logic [DATA_WIDTH-1:0] cdb_value_out;
  logic [TAG_WIDTH-1:0]  cdb_tag_out;
  logic                  cdb_src_out;

  modport master (
    output alu_valid_in, alu_value_in, alu_tag_in,
    output mem_valid_in, mem_value_in, mem_tag_in,
    input  alu_ready_out, mem_ready_out,
    input  cdb_valid_out, cdb_value_out, cdb_tag_out, cdb_src_out
  );

  modport slave (
    input  alu_valid_in, alu_value_in, alu_tag_in,
    input  mem_valid_in, mem_value_in, mem_tag_in,
    output alu_ready_out, mem_ready_out,
    output cdb_valid_out, cdb_value_out, cdb_tag_out, cdb_src_out
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - shares the common data bus between the ALU and the LSB
//
// Purpose: each producer pushes {value, ROB tag} into its own DEPTH-entry FIFO.
//   One FIFO head per cycle is granted and registered onto the CDB.
//   On a conflict, sources are granted alternately. The first conflict goes to the ALU.
// Configuration macro: CDB_ARB_FIXED_PRIO_EN - when defined, the LSB wins every conflict.
// Ports:
//   clk_in        clock, all logic on posedge
//   rst_in        synchronous reset, active-high
//   rdy_in        global enable, low = every register holds
//   need_flush_in misprediction flush, empties both FIFOs and drops the broadcast
//   bus           cdb_arbiter_if.slave, producer handshakes and CDB broadcast
module cdb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int DEPTH      = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          need_flush_in,
  cdb_arbiter_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + TAG_WIDTH;

  // Index 0 = ALU, index 1 = LSB throughout.
  logic [EW-1:0] store   [2][DEPTH];
  logic [PW-1:0] wr_ptr  [2];
  logic [PW-1:0] rd_ptr  [2];
  logic [CW-1:0] cnt     [2];
  logic [EW-1:0] in_data [2];

  logic [1:0]    in_valid;
  logic [1:0]    ready;
  logic [1:0]    nonempty;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          conflict;
  logic          grant_any;
  logic          grant_src;
  logic [EW-1:0] head_data;

  logic                  cdb_valid_q;
  logic [DATA_WIDTH-1:0] cdb_value_q;
  logic [TAG_WIDTH-1:0]  cdb_tag_q;
  logic                  cdb_src_q;

`ifndef CDB_ARB_FIXED_PRIO_EN
  logic rr_last;
`endif

  always_comb begin
    in_valid[0] = bus.alu_valid_in;
    in_valid[1] = bus.mem_valid_in;
    in_data[0]  = {bus.alu_value_in, bus.alu_tag_in};
    in_data[1]  = {bus.mem_value_in, bus.mem_tag_in};
  end

  // Grant and readiness depend only on registered state. A full FIFO
  // therefore refuses a push even in the cycle it pops.
  always_comb begin
    ready     = '0;
    nonempty  = '0;
    push      = '0;
    pop       = '0;
    grant_src = 1'b0;
    for (int s = 0; s < 2; s++) begin
      ready[s]    = cnt[s] < CW'(DEPTH);
      nonempty[s] = cnt[s] != '0;
      push[s]     = in_valid[s] && ready[s];
    end
    conflict  = &nonempty;
    grant_any = |nonempty;
    if (conflict) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
      grant_src = 1'b1;
`else
      grant_src = ~rr_last;
`endif
    end else begin
      grant_src = nonempty[1];
    end
    pop[0]    = grant_any && !grant_src;
    pop[1]    = grant_any && grant_src;
    head_data = store[grant_src][rd_ptr[grant_src]];
  end

  // Entry storage needs no reset; only the pointers and counts define validity.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !need_flush_in) begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          store[s][wr_ptr[s]] <= in_data[s];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < 2; s++) begin
        cnt[s]    <= '0;
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
      end
      cdb_valid_q <= 1'b0;
      cdb_value_q <= '0;
      cdb_tag_q   <= '1;
      cdb_src_q   <= 1'b0;
    end else if (rdy_in) begin
      if (need_flush_in) begin
        for (int s = 0; s < 2; s++) begin
          cnt[s]    <= '0;
          wr_ptr[s] <= '0;
          rd_ptr[s] <= '0;
        end
        cdb_valid_q <= 1'b0;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
          if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
          if (push[s] && !pop[s]) begin
            cnt[s] <= cnt[s] + CW'(1);
          end else if (!push[s] && pop[s]) begin
            cnt[s] <= cnt[s] - CW'(1);
          end
        end
        if (grant_any) begin
          cdb_valid_q <= 1'b1;
          cdb_value_q <= head_data[EW-1:TAG_WIDTH];
          cdb_tag_q   <= head_data[TAG_WIDTH-1:0];
          cdb_src_q   <= grant_src;
        end else begin
          // Idle bus keeps the last value/tag/src so consumers see no glitch.
          cdb_valid_q <= 1'b0;
        end
      end
    end
  end

`ifndef CDB_ARB_FIXED_PRIO_EN
  // Remembers the last conflict winner. Reset to LSB so the ALU wins the first tie.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_last <= 1'b1;
    end else if (rdy_in && !need_flush_in && conflict) begin
      rr_last <= grant_src;
    end
  end
`endif

  assign bus.alu_ready_out = ready[0];
  assign bus.mem_ready_out = ready[1];
  assign bus.cdb_valid_out = cdb_valid_q;
  assign bus.cdb_value_out = cdb_value_q;
  assign bus.cdb_tag_out   = cdb_tag_q;
  assign bus.cdb_src_out   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  localparam int DW    = 32;
  localparam int TW    = 5;
  localparam int DEPTH = 2;

  typedef logic [DW+TW-1:0] ent_t;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic need_flush_in;

  always #5 clk_in = ~clk_in;

  cdb_arbiter_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  cdb_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .need_flush_in (need_flush_in),
    .bus           (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two result queues plus the broadcast register.
  ent_t            q_alu[$];
  ent_t            q_mem[$];
  logic            m_valid;
  logic [DW-1:0]   m_value;
  logic [TW-1:0]   m_tag;
  logic            m_src;
  logic            m_rr;
  bit              model_ok = 0;
  bit              cmp_en = 0;

  always @(posedge clk_in) begin
    bit   pa, pm, g;
    ent_t e;
    if (rst_in) begin
      q_alu.delete();
      q_mem.delete();
      m_valid = 1'b0;
      m_value = '0;
      m_tag   = '1;
      m_src   = 1'b0;
      m_rr    = 1'b1;
      model_ok = 1;
    end else if (model_ok && rdy_in) begin
      if (need_flush_in) begin
        q_alu.delete();
        q_mem.delete();
        m_valid = 1'b0;
      end else begin
        pa = bus.alu_valid_in && (q_alu.size() < DEPTH);
        pm = bus.mem_valid_in && (q_mem.size() < DEPTH);
        if (q_alu.size() > 0 || q_mem.size() > 0) begin
          if (q_alu.size() > 0 && q_mem.size() > 0) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
            g = 1'b1;
`else
            g = !m_rr;
            m_rr = g;
`endif
          end else begin
            g = (q_mem.size() > 0);
          end
          if (g) e = q_mem.pop_front();
          else   e = q_alu.pop_front();
          m_valid = 1'b1;
          m_value = e[DW+TW-1:TW];
          m_tag   = e[TW-1:0];
          m_src   = g;
        end else begin
          m_valid = 1'b0;
        end
        if (pa) q_alu.push_back({bus.alu_value_in, bus.alu_tag_in});
        if (pm) q_mem.push_back({bus.mem_value_in, bus.mem_tag_in});
      end
    end
  end

  logic [TW:0] seen[$];

  always @(negedge clk_in) begin
    if (cmp_en) begin
      chk("alu_ready", bus.alu_ready_out, q_alu.size() < DEPTH);
      chk("mem_ready", bus.mem_ready_out, q_mem.size() < DEPTH);
      chk("cdb_valid", bus.cdb_valid_out, m_valid);
      chk("cdb_value", bus.cdb_value_out, m_value);
      chk("cdb_tag",   bus.cdb_tag_out,   m_tag);
      chk("cdb_src",   bus.cdb_src_out,   m_src);
      if (bus.cdb_valid_out) seen.push_back({bus.cdb_src_out, bus.cdb_tag_out});
    end
  end

  // Producer-side stimulus queues with valid/ready handshake.
  ent_t alu_src[$];
  ent_t mem_src[$];
  bit   saw_alu_full;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pump(input int n);
    for (int i = 0; i < n; i++) begin
      logic acc_a, acc_m;
      ent_t d;
      bus.alu_valid_in = (alu_src.size() > 0);
      if (alu_src.size() > 0) {bus.alu_value_in, bus.alu_tag_in} = alu_src[0];
      bus.mem_valid_in = (mem_src.size() > 0);
      if (mem_src.size() > 0) {bus.mem_value_in, bus.mem_tag_in} = mem_src[0];
      if (!bus.alu_ready_out) saw_alu_full = 1;
      acc_a = bus.alu_valid_in && bus.alu_ready_out && rdy_in && !need_flush_in && !rst_in;
      acc_m = bus.mem_valid_in && bus.mem_ready_out && rdy_in && !need_flush_in && !rst_in;
      tick();
      if (acc_a) d = alu_src.pop_front();
      if (acc_m) d = mem_src.pop_front();
    end
    bus.alu_valid_in = 1'b0;
    bus.mem_valid_in = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.cdb_valid_out, 1'b0);
    chk({tag, "_value"}, bus.cdb_value_out, 32'h0);
    chk({tag, "_tag"},   bus.cdb_tag_out,   5'h1f);
    chk({tag, "_src"},   bus.cdb_src_out,   1'b0);
    chk({tag, "_aready"}, bus.alu_ready_out, 1'b1);
    chk({tag, "_mready"}, bus.mem_ready_out, 1'b1);
  endtask

  task automatic conflict_pair(input string name, input logic first_src);
    bus.alu_valid_in = 1'b1; bus.alu_value_in = 32'hA; bus.alu_tag_in = 5'd1;
    bus.mem_valid_in = 1'b1; bus.mem_value_in = 32'hB; bus.mem_tag_in = 5'd2;
    tick();
    bus.alu_valid_in = 1'b0;
    bus.mem_valid_in = 1'b0;
    tick();
    chk({name, "_first_valid"}, bus.cdb_valid_out, 1'b1);
    chk({name, "_first_src"},   bus.cdb_src_out,   first_src);
    chk({name, "_first_tag"},   bus.cdb_tag_out,   first_src ? 5'd2 : 5'd1);
    tick();
    chk({name, "_second_src"},  bus.cdb_src_out,   !first_src);
    chk({name, "_second_val"},  bus.cdb_value_out, first_src ? 32'hA : 32'hB);
    tick();
    chk({name, "_idle_valid"},  bus.cdb_valid_out, 1'b0);
  endtask

  initial begin
    int n_alu, n_mem;
    bit order_ok;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    need_flush_in = 1'b0;
    bus.alu_valid_in = 1'b0; bus.alu_value_in = '0; bus.alu_tag_in = '0;
    bus.mem_valid_in = 1'b0; bus.mem_value_in = '0; bus.mem_tag_in = '0;
    tick();
    tick();
    rst_in = 1'b0;
    cmp_en = 1;
    chk_reset_outputs("reset");

    // Single ALU push: broadcast exactly two cycles later, then tag holds.
    bus.alu_valid_in = 1'b1; bus.alu_value_in = 32'h11; bus.alu_tag_in = 5'd3;
    tick();
    bus.alu_valid_in = 1'b0;
    tick();
    chk("t1_valid", bus.cdb_valid_out, 1'b1);
    chk("t1_value", bus.cdb_value_out, 32'h11);
    chk("t1_tag",   bus.cdb_tag_out,   5'd3);
    chk("t1_src",   bus.cdb_src_out,   1'b0);
    tick();
    chk("t1_drop_valid", bus.cdb_valid_out, 1'b0);
    chk("t1_hold_tag",   bus.cdb_tag_out,   5'd3);

    // Two conflicts in a row.
`ifdef CDB_ARB_FIXED_PRIO_EN
    conflict_pair("t2a", 1'b1);
    conflict_pair("t2b", 1'b1);
`else
    conflict_pair("t2a", 1'b0);
    conflict_pair("t2b", 1'b1);
`endif

    // ALU burst of 3 against a continuous LSB stream.
    saw_alu_full = 0;
    seen.delete();
    for (int i = 0; i < 3; i++) alu_src.push_back({32'h100 + i, 5'(10 + i)});
    for (int i = 0; i < 8; i++) mem_src.push_back({32'h200 + i, 5'(20 + i)});
    pump(20);
    idle(3);
    chk("t3_alu_full_seen", saw_alu_full, 1'b1);
    n_alu = 0; n_mem = 0; order_ok = 1;
    foreach (seen[i]) begin
      if (seen[i][TW] == 1'b0) begin
        if (seen[i][TW-1:0] != 5'(10 + n_alu)) order_ok = 0;
        n_alu++;
      end else begin
        if (seen[i][TW-1:0] != 5'(20 + n_mem)) order_ok = 0;
        n_mem++;
      end
    end
    chk("t3_alu_count", n_alu, 3);
    chk("t3_mem_count", n_mem, 8);
    chk("t3_order", order_ok, 1'b1);

    // Flush with entries queued and pushes offered in the flush cycle.
    for (int i = 0; i < 3; i++) alu_src.push_back({32'h300 + i, 5'(4 + i)});
    for (int i = 0; i < 3; i++) mem_src.push_back({32'h400 + i, 5'(7 + i)});
    pump(3);
    bus.alu_valid_in = 1'b1; bus.alu_value_in = 32'hDEAD; bus.alu_tag_in = 5'd13;
    bus.mem_valid_in = 1'b1; bus.mem_value_in = 32'hBEEF; bus.mem_tag_in = 5'd14;
    need_flush_in = 1'b1;
    tick();
    need_flush_in = 1'b0;
    bus.alu_valid_in = 1'b0;
    bus.mem_valid_in = 1'b0;
    alu_src.delete();
    mem_src.delete();
    chk("t4_valid",  bus.cdb_valid_out, 1'b0);
    chk("t4_aready", bus.alu_ready_out, 1'b1);
    chk("t4_mready", bus.mem_ready_out, 1'b1);
    seen.delete();
    idle(5);
    chk("t4_no_stale", seen.size(), 0);

    // Stall with one entry queued and one on the bus.
    alu_src.push_back({32'h515, 5'd15});
    alu_src.push_back({32'h616, 5'd16});
    pump(2);
    chk("t5_pre_valid", bus.cdb_valid_out, 1'b1);
    chk("t5_pre_tag",   bus.cdb_tag_out,   5'd15);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_valid", bus.cdb_valid_out, 1'b1);
      chk("t5_hold_tag",   bus.cdb_tag_out,   5'd15);
    end
    rdy_in = 1'b1;
    tick();
    chk("t5_resume_valid", bus.cdb_valid_out, 1'b1);
    chk("t5_resume_tag",   bus.cdb_tag_out,   5'd16);
    chk("t5_resume_value", bus.cdb_value_out, 32'h616);
    idle(2);

    // Reset mid-operation, then alternating pushes across the pointer wrap.
    for (int i = 0; i < 4; i++) alu_src.push_back({32'h700 + i, 5'(4 + i)});
    for (int i = 0; i < 4; i++) mem_src.push_back({32'h800 + i, 5'(8 + i)});
    pump(2);
    bus.alu_valid_in = 1'b1; bus.alu_tag_in = 5'd30;
    bus.mem_valid_in = 1'b1; bus.mem_tag_in = 5'd29;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    bus.alu_valid_in = 1'b0;
    bus.mem_valid_in = 1'b0;
    alu_src.delete();
    mem_src.delete();
    chk_reset_outputs("t6_reset");
    seen.delete();
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      if (i % 2 == 0) begin
        bus.alu_valid_in = 1'b1; bus.alu_value_in = 32'h900 + i; bus.alu_tag_in = 5'(20 + i);
      end else begin
        bus.mem_valid_in = 1'b1; bus.mem_value_in = 32'h900 + i; bus.mem_tag_in = 5'(20 + i);
      end
      tick();
      bus.alu_valid_in = 1'b0;
      bus.mem_valid_in = 1'b0;
    end
    idle(4);
    chk("t6_count", seen.size(), 2 * DEPTH + 1);
    order_ok = (seen.size() == 2 * DEPTH + 1);
    foreach (seen[i]) begin
      if (seen[i] != {1'(i % 2), 5'(20 + i)}) order_ok = 0;
    end
    chk("t6_order", order_ok, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
